// File: rtl/seq_restoring_divider.sv
// Iterative unsigned restoring divider, one quotient bit per clock via an N+1-bit trial subtract.
// Latency: done N+1 cycles after an accepted start (1 cycle when divisor==0); results held until next done.
// Backpressure: start is ignored while busy; a start during the done cycle is accepted with no dead cycle.
module seq_restoring_divider #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state, state_nxt;
    logic [N:0]    r;
    logic [N-1:0]  q;
    logic [N-1:0]  d;
    logic [CW-1:0] cnt;

    logic [N:0]    rs;
    logic [N:0]    t;
    logic [N:0]    r_nxt;
    logic [N-1:0]  q_nxt;
    logic          accept;
    logic          last;

    assign accept = start && (state != RUN);
    assign last   = (cnt == CW'(1));

    // One restoring step: shift in the next dividend bit, keep the difference only if it did not borrow.
    assign rs    = {r[N-1:0], q[N-1]};
    assign t     = rs - {1'b0, d};
    assign r_nxt = t[N] ? rs : t;
    assign q_nxt = {q[N-2:0], ~t[N]};

    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (divisor == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    state_nxt = (divisor == '0) ? DONE : RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r           <= '0;
            q           <= '0;
            d           <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            d <= divisor;
            r <= '0;
            q <= dividend;
            if (divisor == '0) begin
                cnt         <= '0;
                quotient    <= '1;
                remainder   <= dividend;
                div_by_zero <= 1'b1;
            end else begin
                cnt <= CW'(N);
            end
        end else if (state == RUN) begin
            r   <= r_nxt;
            q   <= q_nxt;
            cnt <= cnt - CW'(1);
            // Results are published only on the final step so they stay stable through RUN.
            if (last) begin
                quotient    <= q_nxt;
                remainder   <= r_nxt[N-1:0];
                div_by_zero <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed and random checks of the sequential restoring divider (N=8).
module tb_seq_restoring_divider;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       div_by_zero;

    int n_cmp;
    int n_bad;

    seq_restoring_divider #(.N(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulses start for one cycle, then walks negedges until done; lat counts from the accepting edge.
    task automatic run_div(input logic [7:0] a, input logic [7:0] b, output int lat, output int bcnt);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat   = 0;
        bcnt  = 0;
        while (lat < 30) begin
            lat++;
            if (busy) bcnt++;
            if (done) break;
            @(negedge clk);
        end
        if (!done) lat = -1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        dividend = '0;
        divisor = '0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({busy, done, quotient, remainder, div_by_zero} !== 19'd0) begin
            n_bad++;
            $display("FAIL reset_outputs got %b exp 0", {busy, done, quotient, remainder, div_by_zero});
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({busy, done} !== 2'b00) begin
            n_bad++;
            $display("FAIL idle_after_reset got busy=%b done=%b exp 0 0", busy, done);
        end
    endtask

    task automatic test_basic();
        int lat, bcnt;
        run_div(8'd100, 8'd7, lat, bcnt);
        n_cmp++;
        if (lat !== 9) begin n_bad++; $display("FAIL basic_latency got %0d exp 9", lat); end
        n_cmp++;
        if (bcnt !== 8) begin n_bad++; $display("FAIL basic_busy got %0d exp 8", bcnt); end
        n_cmp++;
        if ({quotient, remainder, div_by_zero} !== {8'd14, 8'd2, 1'b0}) begin
            n_bad++;
            $display("FAIL basic_result got q=%0d r=%0d dbz=%b exp 14 2 0", quotient, remainder, div_by_zero);
        end
        @(negedge clk);
        n_cmp++;
        if ({done, busy, quotient, remainder} !== {1'b0, 1'b0, 8'd14, 8'd2}) begin
            n_bad++;
            $display("FAIL basic_hold got done=%b busy=%b q=%0d r=%0d exp 0 0 14 2", done, busy, quotient, remainder);
        end
    endtask

    task automatic test_vectors();
        logic [7:0] va [4] = '{8'd255, 8'd5, 8'd255, 8'd0};
        logic [7:0] vb [4] = '{8'd1,   8'd9, 8'd255, 8'd3};
        logic [7:0] vq [4] = '{8'd255, 8'd0, 8'd1,   8'd0};
        logic [7:0] vr [4] = '{8'd0,   8'd5, 8'd0,   8'd0};
        int lat, bcnt;
        for (int i = 0; i < 4; i++) begin
            run_div(va[i], vb[i], lat, bcnt);
            n_cmp++;
            if (lat !== 9 || quotient !== vq[i] || remainder !== vr[i]) begin
                n_bad++;
                $display("FAIL vector_%0d got lat=%0d q=%0d r=%0d exp 9 %0d %0d", i, lat, quotient, remainder, vq[i], vr[i]);
            end
        end
    endtask

    task automatic test_div_by_zero();
        int lat, bcnt;
        run_div(8'd37, 8'd0, lat, bcnt);
        n_cmp++;
        if (lat !== 1 || bcnt !== 0) begin
            n_bad++;
            $display("FAIL dbz_timing got lat=%0d busy_cycles=%0d exp 1 0", lat, bcnt);
        end
        n_cmp++;
        if ({quotient, remainder, div_by_zero} !== {8'd255, 8'd37, 1'b1}) begin
            n_bad++;
            $display("FAIL dbz_result got q=%0d r=%0d dbz=%b exp 255 37 1", quotient, remainder, div_by_zero);
        end
        run_div(8'd8, 8'd2, lat, bcnt);
        n_cmp++;
        if ({quotient, remainder, div_by_zero} !== {8'd4, 8'd0, 1'b0} || lat !== 9) begin
            n_bad++;
            $display("FAIL dbz_clear got lat=%0d q=%0d r=%0d dbz=%b exp 9 4 0 0", lat, quotient, remainder, div_by_zero);
        end
    endtask

    task automatic test_start_while_busy();
        int lat;
        @(negedge clk);
        dividend = 8'd200;
        divisor  = 8'd3;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        repeat (3) begin @(negedge clk); lat++; end
        dividend = 8'd9;
        divisor  = 8'd9;
        start    = 1'b1;
        n_cmp++;
        if (quotient !== 8'd4 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL run_hold got q=%0d busy=%b exp 4 1", quotient, busy);
        end
        @(negedge clk);
        lat++;
        start = 1'b0;
        while (!done && lat < 30) begin @(negedge clk); lat++; end
        n_cmp++;
        if (lat !== 9 || quotient !== 8'd66 || remainder !== 8'd2) begin
            n_bad++;
            $display("FAIL ignore_start got lat=%0d q=%0d r=%0d exp 9 66 2", lat, quotient, remainder);
        end
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL ignore_start_idle got busy=%b done=%b exp 0 0", busy, done);
        end
    endtask

    task automatic test_reset_mid_run();
        int lat, bcnt;
        @(negedge clk);
        dividend = 8'd100;
        divisor  = 8'd7;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({busy, done, quotient, remainder, div_by_zero} !== 19'd0) begin
            n_bad++;
            $display("FAIL async_reset got busy=%b done=%b q=%0d r=%0d dbz=%b exp all 0", busy, done, quotient, remainder, div_by_zero);
        end
        @(negedge clk);
        rst = 1'b0;
        run_div(8'd50, 8'd6, lat, bcnt);
        n_cmp++;
        if (lat !== 9 || quotient !== 8'd8 || remainder !== 8'd2) begin
            n_bad++;
            $display("FAIL after_reset got lat=%0d q=%0d r=%0d exp 9 8 2", lat, quotient, remainder);
        end
    endtask

    task automatic test_back_to_back();
        int lat, bcnt;
        logic [7:0] a, b, eq, er;
        logic edz;
        run_div(8'd20, 8'd3, lat, bcnt);
        dividend = 8'd45;
        divisor  = 8'd7;
        start    = 1'b1;
        n_cmp++;
        if (done !== 1'b1 || quotient !== 8'd6 || remainder !== 8'd2) begin
            n_bad++;
            $display("FAIL b2b_first got done=%b q=%0d r=%0d exp 1 6 2", done, quotient, remainder);
        end
        @(negedge clk);
        start = 1'b0;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_no_idle got busy=%b exp 1", busy);
        end
        lat = 1;
        while (!done && lat < 30) begin @(negedge clk); lat++; end
        n_cmp++;
        if (lat !== 9 || quotient !== 8'd6 || remainder !== 8'd3) begin
            n_bad++;
            $display("FAIL b2b_second got lat=%0d q=%0d r=%0d exp 9 6 3", lat, quotient, remainder);
        end
        for (int i = 0; i < 1000; i++) begin
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            if (b == 8'd0) begin
                eq = 8'd255; er = a; edz = 1'b1;
            end else begin
                eq = a / b; er = a % b; edz = 1'b0;
            end
            run_div(a, b, lat, bcnt);
            n_cmp++;
            if (lat < 0 || quotient !== eq || remainder !== er || div_by_zero !== edz) begin
                n_bad++;
                $display("FAIL random_%0d %0d/%0d got lat=%0d q=%0d r=%0d dbz=%b exp q=%0d r=%0d dbz=%b",
                         i, a, b, lat, quotient, remainder, div_by_zero, eq, er, edz);
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_basic();
        test_vectors();
        test_div_by_zero();
        test_start_while_busy();
        test_reset_mid_run();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
